dop_mode_ctrl: RTL and testbench
================================

// Module: dop_mode_ctrl
// PURPOSE
//  Sequences dop_detector and owns the PCM/DSD(DoP) playback mode. Re-arms the detector via clear_success_n.
//  On detection, runs a muted switchover into DSD and tracks DoP markers itself while in DSD.
//  On marker loss, stream idle or disable, runs a muted switchover back to PCM.
//  Sits between the FIFO word stream and the I2S/DSD output mux.
// PARAMETERS
//  DOP_MARKER_0  8'h05     first marker byte (data[15:8])
//  DOP_MARKER_1  8'hfa     second marker byte
//  MUTE_CYCLES   16'd4096  clocks of mute per switchover; even, >=4
//  LOSS_COUNT    4'd4      consecutive bad marker words that end DSD; >=1
//  IDLE_CYCLES   16'd48000 clocks with no data_valid that end DSD
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   reset
//  enable       in   1   1 = auto-detection allowed; 0 = force PCM
//  data         in   16  stream word (same bus as the detector)
//  data_valid   in   1   word qualifier
//  det_success  in   1   dop_detector success
//  det_clear_n  out  1   to dop_detector clear_success_n; low = clear/hold
//  dsd_mode     out  1   1 = output path in DSD
//  mute         out  1   1 = downstream must output silence
//  mode_change  out  1   1-clk pulse on every dsd_mode toggle
// BEHAVIOUR
//  Interface: one clock clk; reset rst_n is asynchronous, active-low.
//  Reset values: PCM state; dsd_mode=0, mute=0, det_clear_n=1, mode_change=0, counters 0.
//  All outputs are registered; they follow the next state.
//  States:
//   PCM     mute=0. det_clear_n = enable. enable & det_success -> MUTE_D.
//   MUTE_D  mute=1, det_clear_n=0; mcnt counts clocks from 0 on entry.
//           dsd_mode:=1 on the edge where mcnt==MUTE_CYCLES/2-1.
//           Exits to DSD on the edge where mcnt==MUTE_CYCLES-1.
//   DSD     mute=0, det_clear_n=0, dsd_mode=1.
//   MUTE_P  mute=1, det_clear_n=0; same mcnt rule, but dsd_mode:=0 at the half-window.
//           Exits to PCM at window end.
//  Exactly MUTE_CYCLES clocks are spent in each MUTE state. mute is high for exactly that window.
//  mode_change pulses only on a real dsd_mode toggle.
//  Marker tracking (MUTE_D and DSD only):
//   - Phase bit toggles on each valid word; phase 0 marks a marker word.
//   - 2-bit seq advances on each marker word. Expected byte is M0 for seq 0/1, M1 for seq 2/3.
//   - bad counter increments on a mismatch and clears on a match.
//   - bad reaching LOSS_COUNT -> MUTE_P.
//  Entry alignment from PCM (det_success seen): seq:=0, phase:=1.
//   - If data_valid is high in that same cycle, the word is the post-marker skip word, so phase:=0.
//  Idle: icnt clears on each valid word and increments otherwise. icnt==IDLE_CYCLES-1 -> MUTE_P.
//  Priority when events coincide:
//   - enable=0 beats loss and idle; loss and idle beat window end.
//   - Loss in MUTE_D before the half-window: enter MUTE_P, mcnt restarts, no mode_change.
//  enable=0 in MUTE_D or DSD -> MUTE_P. In MUTE_P the window completes. In PCM, det_clear_n is held 0.
//  det_success is ignored outside PCM. It is stale-cleared because det_clear_n is 0 for at least MUTE_CYCLES.
//  Reset mid-switchover: immediate PCM; dsd_mode=0, mute=0; no mode_change pulse.
//  Widths: mcnt and icnt are 16 bits; bad is 4 bits and saturates at LOSS_COUNT.
// STRUCTURE
//  Shared include dop_defs.vh:
//   - marker constants 8'h05 / 8'hfa
//   - 2-bit state encoding (PCM=0, MUTE_D=1, DSD=2, MUTE_P=3)
//   - used by dop_detector and this block.
//  One sub-module, dop_marker_tracker: phase, seq and bad counter.
//   - inputs: data[15:8], data_valid, align, align_valid
//   - output: loss
//  FSM, mute/idle counters and output registers stay in dop_mode_ctrl.
// TESTING (MUTE_CYCLES=8, LOSS_COUNT=2, IDLE_CYCLES=20)
//  1 Reset, then det_success=1 for 1 clk, stream clean DoP
//    -> det_clear_n low next clk; mute=1 for 8 clks; dsd_mode rises 4 clks after mute rises (mode_change pulse); mute=0 after.
//  2 In DSD, corrupt 2 consecutive marker words (05->33)
//    -> MUTE_P entered the clk after the 2nd bad word; dsd_mode falls at the half-window; PCM after 8 clks with det_clear_n=1.
//  3 In DSD, one bad marker, then a good marker, then one bad marker -> stays in DSD, mute stays 0.
//  4 In DSD, data_valid held 0 for 20 clks -> MUTE_P, then PCM; total mute 8 clks.
//  5 det_success with data_valid=1 in the same clk, skip word aligned -> no loss.
//    Same stimulus with phase misaligned by 1 word -> loss within 4 words.
//  6 enable=0 during MUTE_D at mcnt=2 -> MUTE_P, no mode_change.
//    Assert rst_n low mid-MUTE_P -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/dop_mode_ctrl_pkg.sv
// rtl/dop_mode_ctrl_pkg.sv - shared DoP marker constants, mode state encoding and marker helper
package dop_mode_ctrl_pkg;

  localparam logic [7:0] DOP_M0 = 8'h05;
  localparam logic [7:0] DOP_M1 = 8'hfa;

  typedef enum logic [1:0] {
    ST_PCM    = 2'd0,
    ST_MUTE_D = 2'd1,
    ST_DSD    = 2'd2,
    ST_MUTE_P = 2'd3
  } mode_state_t;

  // Markers run M0, M0, M1, M1 over a 2-bit sequence counter.
  function automatic logic [7:0] expected_marker(input logic [1:0] seq,
                                                 input logic [7:0] m0,
                                                 input logic [7:0] m1);
    return seq[1] ? m1 : m0;
  endfunction

endpackage

// File: rtl/dop_marker_tracker.sv
// rtl/dop_marker_tracker.sv - follows DoP marker phase/sequence and flags sustained marker loss
module dop_marker_tracker
  import dop_mode_ctrl_pkg::*;
#(
  parameter logic [7:0] MARKER_0   = DOP_M0,
  parameter logic [7:0] MARKER_1   = DOP_M1,
  parameter logic [3:0] LOSS_COUNT = 4'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] marker,
  input  logic       data_valid,
  input  logic       align,
  input  logic       align_valid,
  output logic       loss
);

  logic       phase;
  logic [1:0] seq;
  logic [3:0] bad;
  logic       match;

  assign match = (marker == expected_marker(seq, MARKER_0, MARKER_1));
  assign loss  = (bad >= LOSS_COUNT);

  // Align re-seeds the tracker; otherwise every valid word flips phase and phase-0 words are judged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      seq   <= 2'd0;
      bad   <= 4'd0;
    end else if (align) begin
      seq   <= 2'd0;
      phase <= ~align_valid;  // a word in the align cycle is the post-marker skip word
      bad   <= 4'd0;
    end else if (data_valid) begin
      phase <= ~phase;
      if (!phase) begin
        seq <= seq + 2'd1;
        if (match) begin
          bad <= 4'd0;
        end else if (bad < LOSS_COUNT) begin
          bad <= bad + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/dop_mode_ctrl.sv
// rtl/dop_mode_ctrl.sv - PCM/DSD(DoP) mode sequencer with muted switchovers
module dop_mode_ctrl
  import dop_mode_ctrl_pkg::*;
#(
  parameter logic [7:0]  DOP_MARKER_0 = DOP_M0,
  parameter logic [7:0]  DOP_MARKER_1 = DOP_M1,
  parameter logic [15:0] MUTE_CYCLES  = 16'd4096,
  parameter logic [3:0]  LOSS_COUNT   = 4'd4,
  parameter logic [15:0] IDLE_CYCLES  = 16'd48000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] data,
  input  logic        data_valid,
  input  logic        det_success,
  output logic        det_clear_n,
  output logic        dsd_mode,
  output logic        mute,
  output logic        mode_change
);

  localparam logic [15:0] HALF_LAST = (MUTE_CYCLES >> 1) - 16'd1;
  localparam logic [15:0] WIN_LAST  = MUTE_CYCLES - 16'd1;
  localparam logic [15:0] IDLE_LAST = IDLE_CYCLES - 16'd1;

  mode_state_t state, state_next;
  logic [15:0] mcnt, mcnt_next;
  logic [15:0] icnt, icnt_next;
  logic        dsd_next, mute_next, clear_n_next, change_next;
  logic        align, loss, tracking, idle, abort;
  logic        data_unused;

  // Only the marker byte matters here; the low byte is sample payload.
  assign data_unused = ^data[7:0];

  dop_marker_tracker #(
    .MARKER_0  (DOP_MARKER_0),
    .MARKER_1  (DOP_MARKER_1),
    .LOSS_COUNT(LOSS_COUNT)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .marker     (data[15:8]),
    .data_valid (data_valid),
    .align      (align),
    .align_valid(data_valid),
    .loss       (loss)
  );

  assign tracking = (state == ST_MUTE_D) || (state == ST_DSD);
  assign idle     = tracking && (icnt == IDLE_LAST);
  assign abort    = !enable || loss || idle;

  // Next state, counters and next output values; aborts take precedence over window progress.
  always_comb begin
    state_next = state;
    mcnt_next  = mcnt;
    icnt_next  = 16'd0;
    dsd_next   = dsd_mode;
    align      = 1'b0;
    case (state)
      ST_PCM: begin
        if (enable && det_success) begin
          state_next = ST_MUTE_D;
          mcnt_next  = 16'd0;
          align      = 1'b1;
        end
      end
      ST_MUTE_D: begin
        icnt_next = data_valid ? 16'd0 : icnt + 16'd1;
        if (abort) begin
          state_next = ST_MUTE_P;
          mcnt_next  = 16'd0;
        end else begin
          mcnt_next = mcnt + 16'd1;
          if (mcnt == HALF_LAST) dsd_next = 1'b1;
          if (mcnt == WIN_LAST) begin
            state_next = ST_DSD;
            mcnt_next  = 16'd0;
          end
        end
      end
      ST_DSD: begin
        icnt_next = data_valid ? 16'd0 : icnt + 16'd1;
        if (abort) begin
          state_next = ST_MUTE_P;
          mcnt_next  = 16'd0;
        end
      end
      ST_MUTE_P: begin
        mcnt_next = mcnt + 16'd1;
        if (mcnt == HALF_LAST) dsd_next = 1'b0;
        if (mcnt == WIN_LAST) begin
          state_next = ST_PCM;
          mcnt_next  = 16'd0;
        end
      end
      default: state_next = ST_PCM;
    endcase
    mute_next    = (state_next == ST_MUTE_D) || (state_next == ST_MUTE_P);
    clear_n_next = (state_next == ST_PCM) ? enable : 1'b0;
    change_next  = (dsd_next != dsd_mode);
  end

  // State, counters and registered outputs; reset lands in PCM with no pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PCM;
      mcnt        <= 16'd0;
      icnt        <= 16'd0;
      dsd_mode    <= 1'b0;
      mute        <= 1'b0;
      det_clear_n <= 1'b1;
      mode_change <= 1'b0;
    end else begin
      state       <= state_next;
      mcnt        <= mcnt_next;
      icnt        <= icnt_next;
      dsd_mode    <= dsd_next;
      mute        <= mute_next;
      det_clear_n <= clear_n_next;
      mode_change <= change_next;
    end
  end

endmodule

// File: tb/tb_dop_mode_ctrl.sv
// tb/tb_dop_mode_ctrl.sv - directed self-checking bench for dop_mode_ctrl
module tb_dop_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] data;
  logic        data_valid;
  logic        det_success;
  logic        det_clear_n;
  logic        dsd_mode;
  logic        mute;
  logic        mode_change;

  int checks = 0;
  int errors = 0;
  int widx   = 0;

  always #5 clk = ~clk;

  dop_mode_ctrl #(
    .DOP_MARKER_0(8'h05),
    .DOP_MARKER_1(8'hfa),
    .MUTE_CYCLES (16'd8),
    .LOSS_COUNT  (4'd2),
    .IDLE_CYCLES (16'd20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .data       (data),
    .data_valid (data_valid),
    .det_success(det_success),
    .det_clear_n(det_clear_n),
    .dsd_mode   (dsd_mode),
    .mute       (mute),
    .mode_change(mode_change)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic e_mute, input logic e_dsd,
                      input logic e_mc, input logic e_dcn);
    chk({tag, ".mute"}, mute, e_mute);
    chk({tag, ".dsd_mode"}, dsd_mode, e_dsd);
    chk({tag, ".mode_change"}, mode_change, e_mc);
    chk({tag, ".det_clear_n"}, det_clear_n, e_dcn);
  endtask

  // Clean DoP stream: even index = marker word (05,05,fa,fa repeating), odd = payload word.
  function automatic logic [15:0] word(input int i, input bit corrupt);
    logic [7:0] hi;
    logic [7:0] lo;
    lo = i[7:0];
    if (i % 2 == 0) hi = (((i / 2) % 4) < 2) ? 8'h05 : 8'hfa;
    else            hi = 8'h12;
    if (corrupt && (i % 2 == 0)) hi = 8'h33;
    return {hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit corrupt);
    data_valid = v;
    data       = word(widx, corrupt);
    tick();
    if (v) widx++;
  endtask

  // Aligned detection: det_success arrives with the skip word that precedes a seq-0 marker.
  task automatic enter_dsd(input string tag);
    widx        = 7;
    det_success = 1'b1;
    drive(1'b1, 1'b0);
    det_success = 1'b0;
    chk4({tag, ".entry"}, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0);
      chk4($sformatf("%s.w%0d", tag, i), i < 8, i >= 4, i == 4, 1'b0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    data        = 16'h0000;
    data_valid  = 1'b0;
    det_success = 1'b0;

    // Reset values
    tick();
    tick();
    chk4("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();
    chk4("pcm_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // 1: detection and muted switchover into DSD, then clean DSD
    enter_dsd("t1");
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b0);
      chk4($sformatf("t1.dsd%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // 3: isolated bad markers separated by a good one keep DSD
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) || (i == 4));
      chk4($sformatf("t3.%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // 2: two consecutive bad markers -> MUTE_P the clock after the second one
    drive(1'b1, 1'b1);
    chk4("t2.bad1", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    chk4("t2.skip", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    chk4("t2.bad2", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b0);
      chk4($sformatf("t2.mp%0d", i), i < 9, i < 5, i == 5, i == 9);
    end

    // 4: 20 idle clocks in DSD -> muted switchover back to PCM
    enter_dsd("t4");
    for (int i = 1; i <= 19; i++) begin
      drive(1'b0, 1'b0);
      chk4($sformatf("t4.idle%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b0);
      chk4($sformatf("t4.mp%0d", i), i < 9, i < 5, i == 5, i == 9);
    end

    // 5: detection misaligned by one word -> loss, MUTE_P restarts before dsd_mode ever rises
    widx        = 6;
    det_success = 1'b1;
    drive(1'b1, 1'b0);
    det_success = 1'b0;
    chk4("t5.entry", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 1'b0);
      chk4($sformatf("t5.%0d", i), i < 12, 1'b0, 1'b0, i == 12);
    end

    // 6a: enable dropped in MUTE_D at mcnt=2 -> MUTE_P, no mode_change, PCM with clear held
    widx        = 7;
    det_success = 1'b1;
    drive(1'b1, 1'b0);
    det_success = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    chk4("t6.md2", 1'b1, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b0);
      chk4($sformatf("t6.mp%0d", i), i < 9, 1'b0, 1'b0, 1'b0);
    end
    det_success = 1'b1;
    drive(1'b1, 1'b0);
    det_success = 1'b0;
    chk4("t6.det_ignored", 1'b0, 1'b0, 1'b0, 1'b0);

    // 6b: reset asserted mid-MUTE_P returns outputs asynchronously
    enable = 1'b1;
    enter_dsd("t6r");
    enable = 1'b0;
    drive(1'b1, 1'b0);
    chk4("t6r.mp1", 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("t6r.async", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk4("t6r.held", 1'b0, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    rst_n  = 1'b1;
    data_valid = 1'b0;
    tick();
    chk4("t6r.pcm", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
